// File: rtl/sweep_pkg.sv
// Shared widths and state encoding for the frequency-sweep sequencer.
package sweep_pkg;
  localparam int FREQ_W_DEF  = 24;
  localparam int DWELL_W_DEF = 16;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sweep_state_t;
endpackage

// File: rtl/sweep_dwell_timer.sv
// Per-point dwell counter: load, decrement while enabled, freeze on hold.
// tc marks the last cycle of the current point.
module sweep_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         freeze,
  output logic         tc
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !freeze && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && !freeze && (cnt_q == W'(1));
endmodule

// File: rtl/freq_sweep_ctrl.sv
// Frequency-sweep sequencer driving a DDS tuning word: start..stop in fixed
// steps, each point held for a programmable dwell, single-shot or continuous.
module freq_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int FREQ_W  = FREQ_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               ABORT,
  input  logic               HOLD,
  input  logic               CONT,
  input  logic [FREQ_W-1:0]  F_START,
  input  logic [FREQ_W-1:0]  F_STOP,
  input  logic [FREQ_W-1:0]  F_STEP,
  input  logic [DWELL_W-1:0] DWELL,
  output logic [FREQ_W-1:0]  SET_FREQ,
  output logic               ENB,
  output logic               BUSY,
  output logic               STEP_STB,
  output logic [CNT_W-1:0]   POINT_IDX,
  output logic               DONE,
  output logic               ERR
);
  sweep_state_t       state_q, state_d;
  logic [FREQ_W-1:0]  set_freq_q, set_freq_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               step_stb_q, step_stb_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cont_q, cont_d;
  logic [FREQ_W-1:0]  start_q, start_d;
  logic [FREQ_W-1:0]  stop_q, stop_d;
  logic [FREQ_W-1:0]  step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               timer_load;
  logic [DWELL_W-1:0] timer_val;
  logic               dwell_tc;
  logic [DWELL_W-1:0] dwell_in_eff;
  logic [FREQ_W:0]    next_sum;
  logic               sweep_end;

  assign dwell_in_eff = (DWELL == '0) ? DWELL_W'(1) : DWELL;
  assign timer_val    = (state_q == ST_IDLE) ? dwell_in_eff : dwell_q;

  // One extra bit so a step past the top of the tuning range ends the sweep
  // instead of wrapping to a low frequency.
  assign next_sum  = {1'b0, set_freq_q} + {1'b0, step_q};
  assign sweep_end = next_sum[FREQ_W] || (next_sum[FREQ_W-1:0] > stop_q) ||
                     (step_q == '0);

  sweep_dwell_timer #(
    .W(DWELL_W)
  ) u_dwell (
    .clk     (CLK),
    .srst    (RST),
    .load    (timer_load),
    .load_val(timer_val),
    .en      (state_q == ST_RUN),
    .freeze  (HOLD),
    .tc      (dwell_tc)
  );

  always_comb begin
    state_d    = state_q;
    set_freq_d = set_freq_q;
    idx_d      = idx_q;
    step_stb_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cont_d     = cont_q;
    start_d    = start_q;
    stop_d     = stop_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    timer_load = 1'b0;

    if (ABORT) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            if (F_START > F_STOP) begin
              err_d = 1'b1;
            end else begin
              cont_d     = CONT;
              start_d    = F_START;
              stop_d     = F_STOP;
              step_d     = F_STEP;
              dwell_d    = dwell_in_eff;
              set_freq_d = F_START;
              idx_d      = '0;
              step_stb_d = 1'b1;
              timer_load = 1'b1;
              state_d    = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (dwell_tc) begin
            if (sweep_end) begin
              if (cont_q) begin
                set_freq_d = start_q;
                idx_d      = '0;
                step_stb_d = 1'b1;
                timer_load = 1'b1;
              end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end else begin
              set_freq_d = next_sum[FREQ_W-1:0];
              idx_d      = idx_q + CNT_W'(1);
              step_stb_d = 1'b1;
              timer_load = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      set_freq_q <= '0;
      idx_q      <= '0;
      step_stb_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cont_q     <= 1'b0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
    end else begin
      state_q    <= state_d;
      set_freq_q <= set_freq_d;
      idx_q      <= idx_d;
      step_stb_q <= step_stb_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cont_q     <= cont_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
    end
  end

  assign SET_FREQ  = set_freq_q;
  assign ENB       = (state_q == ST_RUN);
  assign BUSY      = (state_q == ST_RUN);
  assign STEP_STB  = step_stb_q;
  assign POINT_IDX = idx_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl: table of single-shot sweeps plus
// hand-written continuous/hold/abort, start+abort and mid-sweep reset cases.
module tb_freq_sweep_ctrl;
  logic        CLK = 1'b0;
  logic        RST, START, ABORT, HOLD, CONT;
  logic [23:0] F_START, F_STOP, F_STEP;
  logic [15:0] DWELL;
  logic [23:0] SET_FREQ;
  logic        ENB, BUSY, STEP_STB, DONE, ERR;
  logic [15:0] POINT_IDX;

  int checks = 0;
  int failures = 0;

  freq_sweep_ctrl dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .HOLD(HOLD),
    .CONT(CONT), .F_START(F_START), .F_STOP(F_STOP), .F_STEP(F_STEP),
    .DWELL(DWELL), .SET_FREQ(SET_FREQ), .ENB(ENB), .BUSY(BUSY),
    .STEP_STB(STEP_STB), .POINT_IDX(POINT_IDX), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [23:0] fs;
    logic [23:0] fp;
    logic [23:0] st;
    logic [15:0] dw;
    int          npts;
    logic [23:0] last;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int hold_cyc;
    hold_cyc = (v.dw == 16'd0) ? 1 : int'(v.dw);
    F_START = v.fs; F_STOP = v.fp; F_STEP = v.st; DWELL = v.dw;
    CONT = 1'b0; START = 1'b1;
    tick();
    START = 1'b0;
    if (v.err) begin
      chk("err_pulse", 32'(ERR), 32'd1);
      chk("err_busy", 32'(BUSY), 32'd0);
      tick();
      chk("err_one_cycle", 32'(ERR), 32'd0);
      $display("sweep start=%0h stop=%0h rejected", v.fs, v.fp);
      return;
    end
    for (int k = 0; k < v.npts; k++) begin
      for (int c = 0; c < hold_cyc; c++) begin
        chk("freq", 32'(SET_FREQ), 32'(v.fs) + 32'(k) * 32'(v.st));
        chk("idx", 32'(POINT_IDX), 32'(k));
        chk("stb", 32'(STEP_STB), (c == 0) ? 32'd1 : 32'd0);
        chk("enb_run", 32'({ENB, BUSY}), 32'd3);
        chk("done_early", 32'(DONE), 32'd0);
        tick();
      end
    end
    chk("done_pulse", 32'(DONE), 32'd1);
    chk("enb_end", 32'({ENB, BUSY}), 32'd0);
    chk("freq_kept", 32'(SET_FREQ), 32'(v.last));
    chk("stb_end", 32'(STEP_STB), 32'd0);
    tick();
    chk("done_one_cycle", 32'(DONE), 32'd0);
    $display("sweep start=%0h stop=%0h step=%0h dwell=%0d points=%0d done",
             v.fs, v.fp, v.st, v.dw, v.npts);
  endtask

  // Continuous 10..30 step 10, dwell 2, HOLD high for 5 cycles on point 20.
  logic [23:0] c_freq[14] = '{10, 10, 20, 20, 20, 20, 20, 20, 20, 30, 30, 10, 10, 20};
  logic        c_stb[14]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
  logic [15:0] c_idx[14]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 0, 0, 1};

  initial begin
    vecs[0] = '{24'd100, 24'd400, 24'd100, 16'd3, 4, 24'd400, 1'b0};
    vecs[1] = '{24'd100, 24'd350, 24'd100, 16'd0, 3, 24'd300, 1'b0};
    vecs[2] = '{24'hFFFF00, 24'hFFFFFF, 24'h80, 16'd1, 2, 24'hFFFF80, 1'b0};
    vecs[3] = '{24'd500, 24'd400, 24'd100, 16'd2, 0, 24'd0, 1'b1};
    vecs[4] = '{24'd50, 24'd60, 24'd0, 16'd2, 1, 24'd50, 1'b0};
    vecs[5] = '{24'd7, 24'd7, 24'd1, 16'd2, 1, 24'd7, 1'b0};

    RST = 1'b1; START = 1'b0; ABORT = 1'b0; HOLD = 1'b0; CONT = 1'b0;
    F_START = '0; F_STOP = '0; F_STEP = '0; DWELL = '0;
    tick(); tick();
    chk("rst_freq", 32'(SET_FREQ), 32'd0);
    chk("rst_flags", 32'({ENB, BUSY, STEP_STB, DONE, ERR}), 32'd0);
    chk("rst_idx", 32'(POINT_IDX), 32'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Continuous mode with HOLD, a START ignored mid-run, then ABORT.
    F_START = 24'd10; F_STOP = 24'd30; F_STEP = 24'd10; DWELL = 16'd2;
    CONT = 1'b1; START = 1'b1;
    tick();
    START = 1'b0; CONT = 1'b0;
    for (int i = 0; i < 14; i++) begin
      chk("cont_freq", 32'(SET_FREQ), 32'(c_freq[i]));
      chk("cont_stb", 32'(STEP_STB), 32'(c_stb[i]));
      chk("cont_idx", 32'(POINT_IDX), 32'(c_idx[i]));
      chk("cont_enb", 32'({ENB, DONE, ERR}), 32'd4);
      HOLD  = (i >= 2 && i <= 6);
      START = (i == 4);
      F_START = (i == 4) ? 24'd1 : 24'd10;
      ABORT = (i == 13);
      tick();
    end
    HOLD = 1'b0; START = 1'b0; ABORT = 1'b0; F_START = 24'd10;
    chk("abort_enb", 32'({ENB, BUSY}), 32'd0);
    chk("abort_nodone", 32'(DONE), 32'd0);
    chk("abort_freq", 32'(SET_FREQ), 32'd20);
    tick();
    chk("abort_stays", 32'({ENB, DONE, STEP_STB}), 32'd0);
    chk("abort_freq2", 32'(SET_FREQ), 32'd20);
    $display("continuous sweep with hold, aborted at 20");

    // START together with ABORT in IDLE: no ERR, no sweep (invalid range too).
    F_START = 24'd500; F_STOP = 24'd400; START = 1'b1; ABORT = 1'b1;
    tick();
    chk("sa_err", 32'(ERR), 32'd0);
    chk("sa_busy", 32'({ENB, BUSY, STEP_STB}), 32'd0);
    F_START = 24'd100; F_STOP = 24'd400;
    tick();
    chk("sa_valid_busy", 32'({ENB, BUSY, STEP_STB}), 32'd0);
    START = 1'b0; ABORT = 1'b0;
    tick();
    $display("start with abort ignored");

    // Reset mid-sweep, then a normal sweep afterwards.
    F_START = 24'd100; F_STOP = 24'd400; F_STEP = 24'd100; DWELL = 16'd3;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_freq", 32'(SET_FREQ), 32'd200);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_freq", 32'(SET_FREQ), 32'd0);
    chk("mid_rst_flags", 32'({ENB, BUSY, STEP_STB, DONE, ERR}), 32'd0);
    chk("mid_rst_idx", 32'(POINT_IDX), 32'd0);
    tick();
    chk("post_rst_idle", 32'({ENB, BUSY}), 32'd0);
    $display("reset mid-sweep");
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/freq_sweep_ctrl.md
# freq_sweep_ctrl

Frequency-sweep sequencer sitting directly upstream of DDS_and_Hilbert: drives its SET_FREQ and ENB inputs. On a START request it steps the DDS tuning word from a start to a stop value in fixed increments, holding each point for a programmable number of clocks. Single-shot or continuous, with hold and abort controls. Used for automated frequency-response runs of the Hilbert path.

## Interface
- FREQ_W, 24, tuning-word width (matches DDS SET_FREQ)
- DWELL_W, 16, dwell-counter width
- CNT_W, 16, point-index width
- CLK  in  1  single clock, all logic rising-edge
- RST  in  1  synchronous, active-high reset
- START  in  1  sweep request, sampled each cycle; ignored while BUSY
- ABORT  in  1  stop sweep immediately; highest priority
- HOLD  in  1  freeze dwell counter while high (sweep paused, ENB stays 1)
- CONT  in  1  continuous mode, latched at START
- F_START  in  FREQ_W  first tuning word, latched at START
- F_STOP  in  FREQ_W  upper bound, latched at START
- F_STEP  in  FREQ_W  increment, latched at START
- DWELL  in  DWELL_W  cycles per point, latched at START; 0 treated as 1
- SET_FREQ  out  FREQ_W  tuning word to DDS
- ENB  out  1  DDS enable; 1 while running
- BUSY  out  1  sweep in progress
- STEP_STB  out  1  one-cycle pulse each time SET_FREQ takes a new point
- POINT_IDX  out  CNT_W  index of current point, 0 at F_START, wraps modulo 2^CNT_W
- DONE  out  1  one-cycle pulse at normal single-shot completion
- ERR  out  1  one-cycle pulse when START rejected

## Operation
- States: IDLE, RUN.
- IDLE: ENB=0, BUSY=0, SET_FREQ holds last value. START=1 and ABORT=0:
  - F_START > F_STOP: ERR pulse, stay IDLE, nothing latched.
  - Otherwise latch config, SET_FREQ<=F_START, POINT_IDX<=0, dwell counter loaded, STEP_STB=1, -> RUN.
- RUN: ENB=1, BUSY=1. Dwell counter decrements each cycle HOLD=0; frozen while HOLD=1.
- End of dwell: next = cur + step, computed FREQ_W+1 bits wide.
  - carry set, or next > stop, or step = 0: sweep end. CONT=1: SET_FREQ<=start, POINT_IDX<=0, STEP_STB, stay RUN. CONT=0: DONE pulse, -> IDLE.
  - Else SET_FREQ<=next, POINT_IDX+1, STEP_STB, reload dwell.
- Final point is the last value <= F_STOP; F_STOP reached only if aligned.
- ABORT=1 in any state: -> IDLE next cycle, ENB=0, no DONE, SET_FREQ retained. ABORT with START in IDLE: ABORT wins, no ERR.
- START during RUN ignored; latched config unchanged mid-sweep.
- Reset: SET_FREQ=0, ENB=0, BUSY=0, STEP_STB=0, DONE=0, ERR=0, POINT_IDX=0, state IDLE; applies mid-sweep with same result.

## Timing
- START sampled at edge t: at t+1 SET_FREQ=F_START, ENB=BUSY=STEP_STB=1.
- Each point visible on SET_FREQ exactly max(DWELL,1) cycles plus HOLD-high cycles.
- DONE, ENB->0, BUSY->0 in the same cycle, immediately after last point's final dwell cycle.
- All outputs registered; no combinational input-to-output paths.
- STEP_STB, DONE, ERR never high for more than one consecutive cycle.

## Structure
- Package sweep_pkg: FREQ_W, DWELL_W, CNT_W defaults, state enumeration.
- Sub-module sweep_dwell_timer: load/decrement/freeze counter with terminal-count output; FSM and frequency accumulator in top.

## Test plan
- F_START=100, F_STOP=400, F_STEP=100, DWELL=3, CONT=0, START pulse -> SET_FREQ 100,200,300,400 each 3 cycles, STEP_STB x4, POINT_IDX 0..3, DONE one cycle after last, ENB low.
- F_START=100, F_STOP=350, F_STEP=100, DWELL=0 -> points 100,200,300 one cycle each, DONE, 350 never output.
- F_START=0xFFFF00, F_STOP=0xFFFFFF, F_STEP=0x80 -> points FFFF00, FFFF80, then DONE (carry), no wrap to low values.
- CONT=1, 10..30 step 10, DWELL=2; HOLD high 5 cycles on point 20 -> 20 held 7 cycles, sequence repeats 10,20,30,10; ABORT -> ENB=0 next cycle, no DONE, SET_FREQ retained.
- F_START=500, F_STOP=400, START -> ERR pulse, BUSY stays 0; START+ABORT same cycle -> no ERR, no sweep.
- RST asserted mid-sweep -> all outputs reset values next cycle; new START after reset sweeps normally.
